// File: rtl/cache_control_i_pkg.sv
// Shared types and constants for the I-cache controller.
//   state_t      : controller FSM states
//   WR_*         : encodings of the datapath "writing" select
//   CNT_W_DEFAULT: default width of the performance counters
package cache_ctrl_i_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  localparam logic [1:0] WR_FILL = 2'b00;  // line data comes from pmem
  localparam logic [1:0] WR_CPU  = 2'b01;  // merge CPU write data
  localparam logic [1:0] WR_HOLD = 2'b10;  // data array untouched

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/cache_control_i_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : increment request; ignored once count is all-ones
//   count      : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_control_i.sv
// Controller for the direct-mapped I-cache datapath (64 sets, 256-bit lines).
// Resolves CPU requests against the datapath hit flag, performs dirty
// writeback and line fill over the pmem handshake, and keeps saturating
// hit/miss/writeback counters.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   mem_read, mem_write, mem_resp    CPU side
//   pmem_read, pmem_write, pmem_resp physical-memory side
//   hit, dirty_out                   datapath status
//   tag_load, valid_load, dirty_load datapath array write strobes
//   dirty_in, writing                datapath dirty value / data write select
//   clr_counters                     synchronous counter clear
//   hit_count, miss_count, wb_count  performance counters
//
// Handshakes: the CPU holds mem_read/mem_write until a one-cycle mem_resp
// completes the request; the controller holds pmem_read/pmem_write until a
// one-cycle pmem_resp completes the line transfer. mem_read wins when both
// CPU requests are raised together.
module cache_control_i
  import cache_ctrl_i_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             hit,
  input  logic             dirty_out,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic [1:0]       writing,
  input  logic             clr_counters,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  // Observable FSM state for checkers.
  state_t state;
  state_t state_next;

  // Set when a fill completes; the following IDLE lookup is the re-lookup
  // of the missed request and must not be counted as a hit.
  logic refill;

  logic req;
  logic is_write;
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Refill flag: set on fill completion, cleared on any IDLE cycle (either
  // the re-lookup response or a cycle where the request was dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill <= 1'b0;
    end else if ((state == FILL) && pmem_resp) begin
      refill <= 1'b1;
    end else if (state == IDLE) begin
      refill <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          state_next = dirty_out ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    writing    = WR_HOLD;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          hit_inc  = ~refill;
          if (is_write) begin
            writing    = WR_CPU;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else if (req) begin
          miss_inc = 1'b1;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          // Clearing dirty also steers the datapath pmem address from the
          // victim tag to the CPU address for the fill that follows.
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
          wb_inc     = 1'b1;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          writing    = WR_FILL;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counters),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counters),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counters),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control_i.sv
module tb_cache_control_i;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          mem_read;
  logic          mem_write;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic          hit;
  logic          dirty_out;
  logic          tag_load;
  logic          valid_load;
  logic          dirty_load;
  logic          dirty_in;
  logic [1:0]    writing;
  logic          clr_counters;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int checks;
  int errors;

  cache_control_i #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit          (hit),
    .dirty_out    (dirty_out),
    .tag_load     (tag_load),
    .valid_load   (valid_load),
    .dirty_load   (dirty_load),
    .dirty_in     (dirty_in),
    .writing      (writing),
    .clr_counters (clr_counters),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .wb_count     (wb_count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pmem_resp    = 1'b0;
    hit          = 1'b0;
    dirty_out    = 1'b0;
    clr_counters = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000000",
               {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in});
    end
    checks++;
    if (writing !== 2'b10) begin
      errors++; $display("FAIL reset_writing got %b want 10", writing);
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
    end
    step();
    rst_n = 1'b1;
  endtask

  // Cold read miss, clean line, 5-cycle memory latency.
  task automatic test_cold_read();
    step();
    mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL cold_idle got resp=%b pread=%b want 0 0", mem_resp, pmem_read);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      pmem_resp = (i == 4);
      #1;
      checks++;
      if (pmem_read !== 1'b1 || mem_resp !== 1'b0) begin
        errors++; $display("FAIL cold_fill_wait[%0d] got pread=%b resp=%b want 1 0", i, pmem_read, mem_resp);
      end
    end
    checks++;
    if ({writing, tag_load, valid_load, dirty_load, dirty_in} !== 6'b00_1110) begin
      errors++; $display("FAIL cold_fill_strobes got %b want 001110",
                         {writing, tag_load, valid_load, dirty_load, dirty_in});
    end
    step();
    pmem_resp = 1'b0; hit = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL cold_resp got resp=%b pread=%b want 1 0", mem_resp, pmem_read);
    end
    checks++;
    if (miss_count !== 4'd1) begin
      errors++; $display("FAIL cold_miss_count got %0d want 1", miss_count);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd0) begin
      errors++; $display("FAIL cold_hit_count got %0d want 0", hit_count);
    end
  endtask

  task automatic test_read_hit();
    step();
    mem_read = 1'b1; hit = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL read_hit got resp=%b pr=%b pw=%b want 1 0 0", mem_resp, pmem_read, pmem_write);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd1 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL read_hit_count got %0d resp=%b want 1 0", hit_count, mem_resp);
    end
  endtask

  // Write hit dirties the line, then a conflicting read forces a writeback.
  task automatic test_write_hit_dirty_miss();
    step();
    mem_write = 1'b1; hit = 1'b1;
    #1;
    checks++;
    if ({writing, dirty_load, dirty_in, mem_resp} !== 5'b01_111) begin
      errors++; $display("FAIL write_hit got %b want 01111", {writing, dirty_load, dirty_in, mem_resp});
    end
    step();
    idle_inputs();
    mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b1;
    #1;
    checks++;
    if (hit_count !== 4'd2 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL dirty_miss_idle got hits=%0d resp=%b want 2 0", hit_count, mem_resp);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      pmem_resp = (i == 2);
      #1;
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
        errors++; $display("FAIL wb_wait[%0d] got pw=%b pr=%b want 1 0", i, pmem_write, pmem_read);
      end
    end
    checks++;
    if (dirty_load !== 1'b1 || dirty_in !== 1'b0 || tag_load !== 1'b0) begin
      errors++; $display("FAIL wb_done got dl=%b di=%b tl=%b want 1 0 0", dirty_load, dirty_in, tag_load);
    end
    step();
    pmem_resp = 1'b0; dirty_out = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || wb_count !== 4'd1) begin
      errors++; $display("FAIL wb_to_fill got pr=%b pw=%b wb=%0d want 1 0 1", pmem_read, pmem_write, wb_count);
    end
    step();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || tag_load !== 1'b1) begin
      errors++; $display("FAIL dirty_fill_done got pr=%b tl=%b want 1 1", pmem_read, tag_load);
    end
    step();
    pmem_resp = 1'b0; hit = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || miss_count !== 4'd2) begin
      errors++; $display("FAIL dirty_resp got resp=%b misses=%0d want 1 2", mem_resp, miss_count);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd2) begin
      errors++; $display("FAIL dirty_hit_count got %0d want 2", hit_count);
    end
  endtask

  task automatic test_stray_pmem_resp();
    step();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, tag_load, valid_load, dirty_load, mem_resp} !== 6'b0) begin
      errors++; $display("FAIL stray_resp got %b want 000000",
                         {pmem_read, pmem_write, tag_load, valid_load, dirty_load, mem_resp});
    end
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL stray_resp_after got pr=%b pw=%b want 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_read_write_both();
    step();
    mem_read = 1'b1; mem_write = 1'b1; hit = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1 || writing !== 2'b10 || dirty_load !== 1'b0) begin
      errors++; $display("FAIL both_req got resp=%b wr=%b dl=%b want 1 10 0", mem_resp, writing, dirty_load);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd3) begin
      errors++; $display("FAIL both_hit_count got %0d want 3", hit_count);
    end
  endtask

  // Request withdrawn during the fill: no response, flag clears, next hit counts.
  task automatic test_dropped_request();
    step();
    mem_read = 1'b1; hit = 1'b0;
    step();
    mem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL drop_fill got pr=%b want 1", pmem_read);
    end
    step();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (tag_load !== 1'b1 || valid_load !== 1'b1) begin
      errors++; $display("FAIL drop_install got tl=%b vl=%b want 1 1", tag_load, valid_load);
    end
    step();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL drop_no_resp got resp=%b pr=%b want 0 0", mem_resp, pmem_read);
    end
    step();
    mem_read = 1'b1; hit = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL drop_next_hit got resp=%b want 1", mem_resp);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd4 || miss_count !== 4'd3) begin
      errors++; $display("FAIL drop_counts got %0d/%0d want 4/3", hit_count, miss_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    step();
    mem_read = 1'b1; hit = 1'b0;
    step();
    #1;
    checks++;
    if (pmem_read !== 1'b1 || miss_count !== 4'd4) begin
      errors++; $display("FAIL mid_fill_pre got pr=%b misses=%0d want 1 4", pmem_read, miss_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL mid_fill_abort got pr=%b resp=%b want 0 0", pmem_read, mem_resp);
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      errors++; $display("FAIL mid_fill_counters got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
    #1;
    checks++;
    if (pmem_read !== 1'b0 || writing !== 2'b10) begin
      errors++; $display("FAIL mid_fill_idle got pr=%b wr=%b want 0 10", pmem_read, writing);
    end
  endtask

  task automatic test_saturation();
    step();
    mem_read = 1'b1; hit = 1'b1;
    for (int i = 0; i < 16; i++) step();
    #1;
    checks++;
    if (hit_count !== 4'hF) begin
      errors++; $display("FAIL sat_hold got %0d want 15", hit_count);
    end
    clr_counters = 1'b1;
    step();
    clr_counters = 1'b0;
    mem_read = 1'b0;
    #1;
    checks++;
    if (hit_count !== 4'd0) begin
      errors++; $display("FAIL clr_priority got %0d want 0", hit_count);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit_dirty_miss();
    test_stray_pmem_resp();
    test_read_write_both();
    test_dropped_request();
    test_reset_mid_fill();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
